// File: rtl/i2s_capture_pkg.sv
// Shared types and constants for the multi-line I2S capture block.
package i2s_capture_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    UNALIGNED,
    LEFT,
    RIGHT
  } cap_state_t;

  typedef enum logic {
    DR_IDLE,
    DR_SEND
  } drain_state_t;

  function automatic int unsigned chan_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/i2s_slot_shifter.sv
// Per-line slot deserialiser: MSB-first shift register, saturating bit counter, short-slot flag.
module i2s_slot_shifter #(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned OUT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_evt_i,
  input  logic             boundary_i,
  input  logic             sd_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             short_o
);

  localparam int unsigned CNT_W = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);

  logic [SAMPLE_W-1:0] shreg_q;
  logic [CNT_W-1:0]    cnt_q;

  // The bit seen on a boundary belongs to the previous slot, so it only restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (boundary_i) begin
      cnt_q <= '0;
    end else if (bit_evt_i) begin
      if (cnt_q < CNT_FULL) shreg_q <= {shreg_q[SAMPLE_W-2:0], sd_i};
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sample_o = shreg_q[SAMPLE_W-1 -: OUT_W];
  assign short_o  = (cnt_q < CNT_FULL);

endmodule

// File: rtl/i2s_capture_multi.sv
// Multi-line I2S capture with channel-indexed drain stream and sticky error flags.
// Optional per-channel peak tracking is enabled by defining I2S_CAPTURE_PEAK_EN.
module i2s_capture_multi
  import i2s_capture_pkg::*;
#(
  parameter int unsigned NUM_LINES = 2,
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              sck_i,
  input  logic                              ws_i,
  input  logic [NUM_LINES-1:0]              sd_i,
  input  logic                              enable_i,
  input  logic                              clr_i,
  output logic [OUT_W-1:0]                  m_data_o,
  output logic [chan_w(2*NUM_LINES)-1:0]    m_chan_o,
  output logic                              m_last_o,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic                              overrun_o,
  output logic                              framing_err_o,
`ifdef I2S_CAPTURE_PEAK_EN
  output logic [FRAME_CNT_W-1:0]            frame_cnt_o,
  output logic [2*NUM_LINES*OUT_W-1:0]      peak_o
`else
  output logic [FRAME_CNT_W-1:0]            frame_cnt_o
`endif
);

  localparam int unsigned NUM_CH = 2 * NUM_LINES;
  localparam int unsigned CH_W   = chan_w(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic sck_q, ws_last_q, bit_evt, boundary;

  assign bit_evt  = ~sck_q & sck_i;
  assign boundary = bit_evt & (ws_i != ws_last_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q     <= 1'b0;
      ws_last_q <= 1'b0;
    end else begin
      sck_q <= sck_i;
      if (bit_evt) ws_last_q <= ws_i;
    end
  end

  logic [OUT_W-1:0]     samp [NUM_LINES];
  logic [NUM_LINES-1:0] short_slot;

  for (genvar n = 0; n < NUM_LINES; n++) begin : g_line
    i2s_slot_shifter #(
      .SAMPLE_W(SAMPLE_W),
      .SLOT_W  (SLOT_W),
      .OUT_W   (OUT_W)
    ) u_shifter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .bit_evt_i (bit_evt),
      .boundary_i(boundary),
      .sd_i      (sd_i[n]),
      .sample_o  (samp[n]),
      .short_o   (short_slot[n])
    );
  end

  cap_state_t cap_q, cap_d;
  logic save_left, frame_done, short_err;

  always_comb begin
    cap_d      = cap_q;
    save_left  = 1'b0;
    frame_done = 1'b0;
    short_err  = 1'b0;
    if (!enable_i) begin
      cap_d = UNALIGNED;
    end else if (boundary) begin
      unique case (cap_q)
        UNALIGNED: if (!ws_i) cap_d = LEFT;
        LEFT: begin
          if (|short_slot) begin
            short_err = 1'b1;
            cap_d     = UNALIGNED;
          end else begin
            save_left = 1'b1;
            cap_d     = RIGHT;
          end
        end
        RIGHT: begin
          if (|short_slot) begin
            short_err = 1'b1;
            cap_d     = UNALIGNED;
          end else begin
            frame_done = 1'b1;
            cap_d      = LEFT;
          end
        end
        default: cap_d = UNALIGNED;
      endcase
    end
  end

  drain_state_t drain_q, drain_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic done_q, latch, ovr_set;

  always_comb begin
    drain_d = drain_q;
    chan_d  = chan_q;
    latch   = 1'b0;
    ovr_set = 1'b0;
    unique case (drain_q)
      DR_IDLE: begin
        if (done_q) begin
          latch   = 1'b1;
          chan_d  = '0;
          drain_d = DR_SEND;
        end
      end
      DR_SEND: begin
        ovr_set = done_q;
        if (m_ready_i) begin
          if (chan_q == LAST_CH) drain_d = DR_IDLE;
          else chan_d = chan_q + CH_W'(1);
        end
      end
    endcase
  end

  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic overrun_q, framing_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_q       <= UNALIGNED;
      done_q      <= 1'b0;
      drain_q     <= DR_IDLE;
      chan_q      <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      framing_q   <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      done_q  <= frame_done;
      drain_q <= drain_d;
      chan_q  <= chan_d;
      if (latch) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      overrun_q <= ovr_set | (overrun_q & ~clr_i);
      framing_q <= short_err | (framing_q & ~clr_i);
    end
  end

  // Right samples are read straight from the shifters: no bit event can follow a boundary
  // on the very next clock, so they are still intact when the bank latches.
  logic [OUT_W-1:0] cap_l_q    [NUM_LINES];
  logic [OUT_W-1:0] frame_samp [NUM_CH];
  logic [OUT_W-1:0] hold_q     [NUM_CH];

  for (genvar n = 0; n < NUM_LINES; n++) begin : g_frame
    assign frame_samp[2*n]   = cap_l_q[n];
    assign frame_samp[2*n+1] = samp[n];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_LINES; n++) cap_l_q[n] <= '0;
      for (int c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
    end else begin
      if (save_left) begin
        for (int n = 0; n < NUM_LINES; n++) cap_l_q[n] <= samp[n];
      end
      if (latch) begin
        for (int c = 0; c < NUM_CH; c++) hold_q[c] <= frame_samp[c];
      end
    end
  end

  assign m_valid_o     = (drain_q == DR_SEND);
  assign m_data_o      = hold_q[chan_q];
  assign m_chan_o      = chan_q;
  assign m_last_o      = m_valid_o && (chan_q == LAST_CH);
  assign overrun_o     = overrun_q;
  assign framing_err_o = framing_q;
  assign frame_cnt_o   = frame_cnt_q;

`ifdef I2S_CAPTURE_PEAK_EN
  function automatic logic [OUT_W-1:0] abs_sat(input logic [OUT_W-1:0] x);
    if (!x[OUT_W-1]) return x;
    if (x == {1'b1, {(OUT_W-1){1'b0}}}) return {1'b0, {(OUT_W-1){1'b1}}};
    return -x;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_peak
    logic [OUT_W-1:0] pk_q, base, mag;
    assign base = clr_i ? '0 : pk_q;
    assign mag  = abs_sat(frame_samp[c]);
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pk_q <= '0;
      else if (latch) pk_q <= (mag > base) ? mag : base;
      else if (clr_i) pk_q <= '0;
    end
    assign peak_o[c*OUT_W +: OUT_W] = pk_q;
  end
`endif

endmodule

// File: tb/tb_i2s_capture_multi.sv
// Directed bench for i2s_capture_multi: two lines, 24-bit slots in 32-SCK half-frames.
module tb_i2s_capture_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic [1:0]  sd = 2'b00;
  logic        enable = 1'b1;
  logic        clr = 1'b0;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic        m_last, m_valid, overrun, framing_err;
  logic [15:0] frame_cnt;
`ifdef I2S_CAPTURE_PEAK_EN
  logic [63:0] peak;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_capture_multi #(
    .NUM_LINES(2),
    .SAMPLE_W (24),
    .SLOT_W   (32),
    .OUT_W    (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sck_i        (sck),
    .ws_i         (ws),
    .sd_i         (sd),
    .enable_i     (enable),
    .clr_i        (clr),
    .m_data_o     (m_data),
    .m_chan_o     (m_chan),
    .m_last_o     (m_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .overrun_o    (overrun),
    .framing_err_o(framing_err),
    .frame_cnt_o  (frame_cnt)
`ifdef I2S_CAPTURE_PEAK_EN
    ,
    .peak_o       (peak)
`endif
  );

  logic [15:0] q_data [$];
  logic [1:0]  q_chan [$];
  logic        q_last [$];

  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_chan.push_back(m_chan);
      q_last.push_back(m_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_chan.delete();
    q_last.delete();
  endtask

  // n SCK periods with fixed ws; edge 0 carries a junk 1, edges 1..24 the sample MSB first.
  task automatic bits(input logic w, input logic [23:0] d0, input logic [23:0] d1, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sck   = 1'b0;
      ws    = w;
      sd[0] = (k >= 1 && k <= 24) ? d0[24-k] : 1'b1;
      sd[1] = (k >= 1 && k <= 24) ? d1[24-k] : 1'b1;
      @(negedge clk);
      @(negedge clk);
      sck = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [23:0] l0, input logic [23:0] r0,
                            input logic [23:0] l1, input logic [23:0] r1);
    bits(1'b0, l0, l1, 32);
    bits(1'b1, r0, r1, 32);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    sck     = 1'b0;
    ws      = 1'b0;
    sd      = 2'b00;
    enable  = 1'b1;
    clr     = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_beats(input string tag, input logic [23:0] s0, input logic [23:0] s1,
                             input logic [23:0] s2, input logic [23:0] s3);
    logic [23:0] s [4];
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    s[3] = s3;
    check({tag, " beat count"}, q_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (q_data.size() == 0) break;
      check($sformatf("%s data%0d", tag, i), q_data.pop_front(), s[i][23:8]);
      check($sformatf("%s chan%0d", tag, i), q_chan.pop_front(), i);
      check($sformatf("%s last%0d", tag, i), q_last.pop_front(), (i == 3));
    end
    clear_q();
  endtask

  initial begin
    // Reset state and one aligned frame
    apply_reset();
    check("rst valid", m_valid, 0);
    check("rst data", m_data, 0);
    check("rst chan", m_chan, 0);
    check("rst last", m_last, 0);
    check("rst overrun", overrun, 0);
    check("rst framing", framing_err, 0);
    check("rst frame_cnt", frame_cnt, 0);
    bits(1'b1, 24'h0, 24'h0, 32);
    send_frame(24'h123456, 24'hABCDEF, 24'h7FFFFF, 24'h800000);
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (10) @(negedge clk);
    check_beats("t1", 24'h123456, 24'hABCDEF, 24'h7FFFFF, 24'h800000);
    check("t1 frame_cnt", frame_cnt, 1);
    check("t1 valid idle", m_valid, 0);

    // Backpressure across a frame boundary drops the second frame
    apply_reset();
    bits(1'b1, 24'h0, 24'h0, 32);
    send_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    m_ready = 1'b0;
    send_frame(24'h999999, 24'h888888, 24'h777777, 24'h666666);
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (4) @(negedge clk);
    check("t2 overrun", overrun, 1);
    check("t2 stuck valid", m_valid, 1);
    check("t2 stuck data", m_data, 16'h1111);
    check("t2 stuck chan", m_chan, 0);
    check("t2 stuck last", m_last, 0);
    check("t2 frame_cnt", frame_cnt, 1);
    check("t2 no beats", q_data.size(), 0);
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_beats("t2", 24'h111111, 24'h222222, 24'h333333, 24'h444444);
    pulse_clr();
    check("t2 overrun clr", overrun, 0);

    // Enable dropped mid-frame, raised mid right slot
    apply_reset();
    bits(1'b1, 24'h0, 24'h0, 32);
    bits(1'b0, 24'hDEADBE, 24'hEFCAFE, 32);
    enable = 1'b0;
    bits(1'b1, 24'h0, 24'h0, 10);
    enable = 1'b1;
    bits(1'b1, 24'h0, 24'h0, 22);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24'h55AA55, 24'hAA55AA);
    check("t3 no early beats", q_data.size(), 0);
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (10) @(negedge clk);
    check_beats("t3", 24'h0F0F0F, 24'hF0F0F0, 24'h55AA55, 24'hAA55AA);
    check("t3 frame_cnt", frame_cnt, 1);

    // Short left slot: framing error, realign on next falling ws
    apply_reset();
    bits(1'b1, 24'h0, 24'h0, 32);
    bits(1'b0, 24'hFFFFFF, 24'hFFFFFF, 10);
    bits(1'b1, 24'h0, 24'h0, 32);
    check("t4 framing", framing_err, 1);
    check("t4 overrun", overrun, 0);
    check("t4 no beats", q_data.size(), 0);
    send_frame(24'h000001, 24'hFFFFFF, 24'h13579B, 24'h2468AC);
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (10) @(negedge clk);
    check_beats("t4", 24'h000001, 24'hFFFFFF, 24'h13579B, 24'h2468AC);
    check("t4 frame_cnt", frame_cnt, 1);
    check("t4 framing sticky", framing_err, 1);
    pulse_clr();
    check("t4 framing clr", framing_err, 0);

    // Reset in the middle of a drain
    apply_reset();
    bits(1'b1, 24'h0, 24'h0, 32);
    send_frame(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
    m_ready = 1'b0;
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (4) @(negedge clk);
    check("t5 valid", m_valid, 1);
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    check("t5 partial beats", q_data.size(), 2);
    check("t5 chan after 2", m_chan, 2);
    #2 rst = 1'b1;
    #1;
    check("t5 valid async", m_valid, 0);
    check("t5 frame_cnt rst", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    clear_q();
    bits(1'b1, 24'h0, 24'h0, 32);
    send_frame(24'hFEDCBA, 24'h765432, 24'h0AB0CD, 24'hC0FFEE);
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (10) @(negedge clk);
    check_beats("t5", 24'hFEDCBA, 24'h765432, 24'h0AB0CD, 24'hC0FFEE);
    check("t5 frame_cnt", frame_cnt, 1);

`ifdef I2S_CAPTURE_PEAK_EN
    // Peak tracking on channel 0
    apply_reset();
    check("t6 peak rst", peak[15:0], 0);
    bits(1'b1, 24'h0, 24'h0, 32);
    send_frame(24'hC00000, 24'h0, 24'h0, 24'h0);
    send_frame(24'h100000, 24'h0, 24'h0, 24'h0);
    bits(1'b0, 24'h0, 24'h0, 1);
    repeat (10) @(negedge clk);
    check("t6 peak ch0", peak[15:0], 16'h4000);
    pulse_clr();
    check("t6 peak clr", peak[15:0], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_capture_multi.md
Name: i2s_capture_multi

Overview:
Parametrised successor to the single-line 24-bit I2S capture. Deserialises NUM_LINES stereo I2S data lines sharing one SCK/WS pair. Produces left and right samples per line, truncated to OUT_W. Emits each completed frame as a channel-indexed valid/ready stream into the ping-pong RAM or the DSP path, with overrun and framing-error reporting.

Parameters:
NUM_LINES, 2, number of sd_i lines; each carries L and R, giving NUM_CH = 2*NUM_LINES channels.
SAMPLE_W, 24, bits captured per slot, MSB first; must be < SLOT_W.
SLOT_W, 32, SCK periods per WS half-frame; sizes the bit counter, which saturates at SLOT_W-1.
OUT_W, 16, output width; the top OUT_W bits of the sample, truncated, sign preserved; OUT_W <= SAMPLE_W.

Ports:
clk_i  in  1  system clock; SCK/WS are generated in this domain.
rst_i  in  1  reset, asynchronous, active-high.
sck_i  in  1  I2S bit clock from i2s_clock_gen.
ws_i  in  1  word select; 0 = left, 1 = right.
sd_i  in  NUM_LINES  serial data, one bit per line.
enable_i  in  1  capture enable.
clr_i  in  1  one-cycle pulse that clears the sticky flags.
m_data_o  out  OUT_W  sample.
m_chan_o  out  CH_W = max(1, clog2(NUM_CH))  channel index; line n gives L = 2n, R = 2n+1.
m_last_o  out  1  high on the final channel of a frame.
m_valid_o  out  1  stream valid.
m_ready_i  in  1  stream ready.
overrun_o  out  1  sticky: a completed frame was dropped.
framing_err_o  out  1  sticky: a slot was shorter than SAMPLE_W bits.
frame_cnt_o  out  16  count of accepted frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: all outputs 0; capture FSM in UNALIGNED; drain FSM in DR_IDLE; holding bank 0.
- Edge detection:
  - sck_i is registered as sck_q.
  - A bit event is sck_q == 0 && sck_i == 1.
  - sd_i and ws_i are sampled on the same clk_i cycle as the bit event.
- Slot boundary: at a bit event where ws_i != ws_last. On that event:
  - the slot bit counter resets to 0;
  - the bit sampled on that event belongs to the previous slot and is discarded.
- Bit capture: on each later bit event, the bit is shifted in while count < SAMPLE_W. Bits at count >= SAMPLE_W are ignored.
- Capture FSM:
  - UNALIGNED -> LEFT on a boundary with ws 1 -> 0.
  - LEFT -> RIGHT on a boundary with ws 0 -> 1.
  - RIGHT -> LEFT on a boundary with ws 1 -> 0. This transition is frame complete.
  - enable_i = 0 forces UNALIGNED and discards any partial frame. A drain already in progress still finishes.
- Short slot: a boundary reached with count < SAMPLE_W.
  - Sets framing_err_o.
  - The current frame is discarded and the FSM goes to UNALIGNED, then realigns on the next ws falling edge.
- Frame complete, drain idle:
  - Next cycle: all NUM_CH samples are latched into the holding bank and frame_cnt_o increments.
  - The cycle after the latch: m_valid_o = 1 with m_chan_o = 0.
  - Latency from the completing bit event to first valid is 2 clk_i cycles.
- Frame complete, drain busy:
  - Frame dropped, overrun_o set, frame_cnt_o unchanged.
  - The holding bank is never overwritten while draining.
- Drain:
  - One channel per valid && ready, in ascending m_chan_o order.
  - m_data_o, m_chan_o and m_last_o are stable while valid && !ready.
  - After the beat carrying m_last_o, m_valid_o = 0 for at least one cycle before the next frame.
- clr_i clears both sticky flags. If a set event and clr_i occur in the same cycle, set wins.
- Reset mid-operation: m_valid_o drops asynchronously and the partial drain is lost. After release, capture resyncs via UNALIGNED.

Optional Feature:
Macro I2S_CAPTURE_PEAK_EN adds peak tracking.
- With the macro defined:
  - Adds port peak_o, out, NUM_CH*OUT_W: per-channel absolute peak of the OUT_W value.
  - Updated on each latch as max(peak, |x|).
  - |most negative value| saturates to 2^(OUT_W-1)-1.
  - clr_i also zeroes every peak.
- Without the macro: no peak_o port and no peak logic.

Decomposition:
- Package i2s_capture_pkg holds:
  - cap_state_t (UNALIGNED, LEFT, RIGHT);
  - drain_state_t (DR_IDLE, DR_SEND);
  - the FRAME_CNT_W = 16 constant;
  - a chan_w(num_ch) function.
- Sub-module i2s_slot_shifter, instantiated once per line:
  - SAMPLE_W shift register, bit counter and short-slot flag;
  - driven by a common bit-event strobe and a common boundary strobe.

Test Plan:
All scenarios use NUM_LINES=2, SAMPLE_W=24, OUT_W=16, SLOT_W=32, and m_ready_i=1 unless stated.
1. One aligned frame with line0 L=0x123456, R=0xABCDEF and line1 L=0x7FFFFF, R=0x800000 -> beats 0x1234, 0xABCD, 0x7FFF, 0x8000 on chan 0..3; m_last_o on chan 3 only; frame_cnt_o = 1.
2. m_ready_i held 0 across the next frame boundary -> overrun_o = 1, the first frame stays stable on the output, the second frame is dropped, frame_cnt_o stays 1; a clr_i pulse -> overrun_o = 0.
3. enable_i raised while ws = 1 mid-slot -> no output until a full L+R following the next ws falling edge; first frame data is correct.
4. ws toggled after 10 SCKs in a left slot -> framing_err_o = 1, no beats, realign; the next clean frame outputs correctly.
5. rst_i asserted after 2 of 4 beats -> m_valid_o = 0 immediately and frame_cnt_o = 0; after release the next full frame outputs all 4 beats.
6. With I2S_CAPTURE_PEAK_EN, samples 0xC00000 then 0x100000 on chan 0 -> peak 0x4000; a clr_i pulse -> 0.
